// File: rtl/disp_bcd_formatter.sv
// disp_bcd_formatter
//   Converts a binary value to packed BCD with the shift-add-3 method, one
//   bit per clock, and presents the result to the seven-segment scanner.
//   Outputs update atomically only when a conversion completes.
//   Optional build macro: LZ_BLANK_EN
//     defined     -> leading-zero digits are masked off in output_valid
//     not defined -> output_valid is all ones after every conversion
module disp_bcd_formatter #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   output_data,
    output logic [DIGITS-1:0]     output_valid
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10_minus1(DIGITS);
    localparam logic [DW-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [BIN_W-1:0]  shreg_q,   shreg_d;
    logic [DW-1:0]     bcd_q,     bcd_d;
    logic              ovf_cap_q, ovf_cap_d;
    logic              done_q,    done_d;
    logic              ovf_q,     ovf_d;
    logic [DW-1:0]     data_q,    data_d;
    logic [DIGITS-1:0] valid_q,   valid_d;

    logic [DW-1:0]     bcd_adj;
    logic [DW-1:0]     result;
    logic [DIGITS-1:0] mask;

    // Add-3 correction: every nibble >= 5 gets +3 before the shift (no carry out).
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Final result (saturated on overflow) and the scanner digit mask.
    always_comb begin
        logic nz;
        result = ovf_cap_q ? ALL_NINES : bcd_q;
        mask   = '0;
        nz     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz      = nz | (result[4*i +: 4] != 4'd0);
            mask[i] = nz | (i == 0);
        end
`ifndef LZ_BLANK_EN
        mask = '1;
`endif
    end

    // Next-state logic for the conversion FSM and the output registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        ovf_cap_d = ovf_cap_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        data_d    = data_q;
        valid_d   = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = bin_value;
                    bcd_d     = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    ovf_cap_d = (64'(bin_value) > MAX_VAL);
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // One bit per cycle; once all bits are consumed the
                // accumulator is stable and we move on to publish it.
                if (cnt_q != '0) begin
                    bcd_d   = {bcd_adj[DW-2:0], shreg_q[BIN_W-1]};
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                data_d  = result;
                valid_d = mask;
                ovf_d   = ovf_cap_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bcd_q     <= '0;
            ovf_cap_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= DIGITS'(1);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            ovf_cap_q <= ovf_cap_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign output_data  = data_q;
    assign output_valid = valid_q;

endmodule

// File: doc/disp_bcd_formatter.md
Name: disp_bcd_formatter

Overview:
Upstream display-formatting stage for the 8-digit seven-segment scanner. Takes a binary value from the game controller (guess, target, attempt count) and converts it to packed BCD by iterative shift-add-3, one bit per cycle. It then drives the scanner's 32-bit digit bus and 8-bit digit-valid mask, with leading-zero blanking. Outputs are registered and change atomically only when a conversion completes, so the scanner never shows a partial result.

Parameters:
DIGITS, 8, number of BCD digits produced; output_data width = 4*DIGITS.
BIN_W, 27, binary input width; must satisfy 2^BIN_W > 10^DIGITS - 1 (default covers 0..134,217,727).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
bin_value  input  BIN_W  unsigned value to display; sampled only on an accepted start
start  input  1  conversion request; accepted only when busy=0
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse in the cycle output_data/output_valid first show the new result
overflow  output  1  registered with result; 1 if the last accepted value exceeded 10^DIGITS - 1
output_data  output  4*DIGITS  packed BCD, digit 0 in [3:0], held between conversions
output_valid  output  DIGITS  per-digit enable for the scanner, bit i = digit i

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, overflow=0, output_data=0, output_valid=1 (only digit 0 lit, showing "0"), FSM=IDLE, iteration counter=0.
- FSM states:
  - IDLE: start=1 -> capture bin_value into the shift register, clear the BCD accumulator, load counter=BIN_W, go CONVERT, busy=1 from the next cycle.
  - CONVERT: per cycle, first add 3 to every BCD nibble >=5. Then shift {bcd, shreg} left one bit and decrement the counter. When the counter reaches 0 after the shift, go FINISH.
  - FINISH: one cycle. Compute the valid mask, register output_data/output_valid/overflow, assert done for the following cycle, return to IDLE (busy=0 in that same done cycle).
- Latency: if start is sampled at edge N, the new outputs and done=1 are visible after edge N+BIN_W+2 (29 cycles at default). The next start is accepted in the done cycle.
- start while busy=1 is ignored; the value is not queued and no error is flagged.
- Overflow: compare the captured value against 10^DIGITS - 1 at capture. If greater, the result is saturated to all nines (32'h9999_9999 at default), overflow=1, and output_valid is all ones. Otherwise overflow=0.
- Leading-zero blanking: output_valid[i]=1 iff i==0 or any digit j>=i is nonzero. Value 0 gives mask 1.
- Arithmetic: each nibble add-3 is 4-bit, no carry out; the conversion is exact for all non-overflow inputs.
- Outputs hold their last result indefinitely while IDLE; bin_value changes without start have no effect.
- Reset mid-conversion aborts immediately: all outputs return to reset values, and no done pulse is issued.

Optional Feature:
LZ_BLANK_EN.
- Defined: leading-zero blanking as above.
- Not defined: output_valid is forced all ones on every completed conversion (reset value still 1), so all digits including leading zeros are displayed.
- Conversion data, latency and overflow behaviour are identical in both builds.

Test Plan:
- After reset, no start -> output_data=0, output_valid=8'h01, busy=0, done=0.
- bin_value=12345, start 1 cycle -> busy for the conversion, done exactly 29 cycles after the start edge, output_data=32'h0001_2345, output_valid=8'h1F, overflow=0.
- bin_value=0 then 99,999,999 back-to-back (second start in the done cycle) -> first result 0/8'h01, second 32'h9999_9999/8'hFF, overflow=0.
- bin_value=100,000,000 -> output_data=32'h9999_9999, output_valid=8'hFF, overflow=1.
- start for 7, then start pulses with 555 during busy -> only 7 converted (data 32'h7, valid 8'h01), one done pulse. Then rst asserted mid-way through a conversion of 42 -> outputs return to reset values, no done.
- Build without LZ_BLANK_EN, bin_value=305 -> output_data=32'h0000_0305, output_valid=8'hFF.
